// File: rtl/link_rx.sv
// rtl/link_rx.sv - 8N1 UART receiver and 5-byte packet parser for the opponent link
module link_rx #(
  parameter int CLKS_PER_BIT = 651,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       err_clr,
  output logic       start_game,
  output logic [5:0] seed_x,
  output logic [5:0] seed_y,
  output logic       seed_vld,
  output logic [1:0] dir,
  output logic       dir_vld,
  output logic       con_error
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT + 1);
  localparam int TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    P_SYNC, P_CMD, P_D0, P_D1, P_SUM
  } p_state_t;

  rx_state_t     r_rx_state;
  p_state_t      r_p_state;
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_byte_vld;
  logic          r_frame_err;
  logic [7:0]    r_cmd;
  logic [7:0]    r_d0;
  logic [7:0]    r_d1;
  logic [TW-1:0] r_to_cnt;

  logic          w_sum_ok;
  logic          w_sum_err;
  logic          w_timeout;
  logic          w_err_set;

  // Synchronize rx and run the byte-level receiver; emits one-cycle byte or framing strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= R_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          r_clk_cnt <= '0;
          if (r_rx_prev && !r_rx_sync) r_rx_state <= R_START;
        end
        R_START: begin
          // Mid-start-bit check rejects short low glitches without flagging an error
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_rx_state <= r_rx_sync ? R_IDLE : R_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) r_rx_state <= R_STOP;
            else                   r_bit_cnt  <= r_bit_cnt + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            if (r_rx_sync) begin
              r_byte     <= r_shift;
              r_byte_vld <= 1'b1;
              r_rx_state <= R_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_state  <= R_WAIT_HIGH;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        R_WAIT_HIGH: begin
          if (r_rx_sync) r_rx_state <= R_IDLE;
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  // Fault detection for the current cycle: bad checksum, inter-byte timeout, framing
  always_comb begin
    w_sum_ok  = (r_byte == (r_cmd ^ r_d0 ^ r_d1));
    w_sum_err = r_byte_vld && (r_p_state == P_SUM) && !w_sum_ok;
    w_timeout = (r_p_state != P_SYNC) && !r_byte_vld && (r_to_cnt == TO_LAST);
    w_err_set = r_frame_err || w_sum_err || w_timeout;
  end

  // Packet parser, timeout counter, command outputs and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_state  <= P_SYNC;
      r_cmd      <= '0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_to_cnt   <= '0;
      start_game <= 1'b0;
      seed_x     <= '0;
      seed_y     <= '0;
      seed_vld   <= 1'b0;
      dir        <= '0;
      dir_vld    <= 1'b0;
      con_error  <= 1'b0;
    end else begin
      start_game <= 1'b0;
      seed_vld   <= 1'b0;
      dir_vld    <= 1'b0;

      // A new fault overrides a simultaneous clear
      if (w_err_set)    con_error <= 1'b1;
      else if (err_clr) con_error <= 1'b0;

      if ((r_p_state == P_SYNC) || r_byte_vld || w_timeout) r_to_cnt <= '0;
      else                                                   r_to_cnt <= r_to_cnt + 1'b1;

      if (r_frame_err || w_timeout) begin
        r_p_state <= P_SYNC;
      end else if (r_byte_vld) begin
        case (r_p_state)
          P_SYNC: if (r_byte == SYNC_BYTE) r_p_state <= P_CMD;
          P_CMD: begin
            r_cmd     <= r_byte;
            r_p_state <= P_D0;
          end
          P_D0: begin
            r_d0      <= r_byte;
            r_p_state <= P_D1;
          end
          P_D1: begin
            r_d1      <= r_byte;
            r_p_state <= P_SUM;
          end
          P_SUM: begin
            r_p_state <= P_SYNC;
            if (w_sum_ok) begin
              case (r_cmd)
                8'h01: start_game <= 1'b1;
                8'h02: begin
                  seed_x   <= r_d0[5:0];
                  seed_y   <= r_d1[5:0];
                  seed_vld <= 1'b1;
                end
                8'h03: begin
                  dir     <= r_d0[1:0];
                  dir_vld <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          default: r_p_state <= P_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_link_rx.sv
// tb/tb_link_rx.sv - scoreboard bench for link_rx with random and directed packets
module tb_link_rx;

  localparam int CPB = 16;
  localparam int TO  = 600;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       err_clr;
  logic       start_game;
  logic [5:0] seed_x;
  logic [5:0] seed_y;
  logic       seed_vld;
  logic [1:0] dir;
  logic       dir_vld;
  logic       con_error;

  link_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .rx(rx), .err_clr(err_clr),
    .start_game(start_game), .seed_x(seed_x), .seed_y(seed_y), .seed_vld(seed_vld),
    .dir(dir), .dir_vld(dir_vld), .con_error(con_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [5:0] x;
    logic [5:0] y;
    logic [1:0] d;
    int         c0;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_fail = 0;
  logic       exp_err = 1'b0;
  logic [5:0] m_x = '0;
  logic [5:0] m_y = '0;
  logic [1:0] m_d = '0;
  int         act_kind;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per output pulse, checks held values every cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_x = '0;
      m_y = '0;
      m_d = '0;
    end else begin
      if (start_game || seed_vld || dir_vld) begin
        chk("one_pulse_at_a_time", 32'(start_game) + 32'(seed_vld) + 32'(dir_vld), 1);
        act_kind = start_game ? 1 : (seed_vld ? 2 : 3);
        if (q.size() == 0) begin
          chk("unexpected_pulse_kind", act_kind, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", act_kind, e.kind);
          chk("pulse_latency_ok",
              32'((cyc >= e.c0 + 9*CPB + CPB/2 + 1) && (cyc <= e.c0 + 9*CPB + CPB/2 + 7)), 1);
          if (e.kind == 2) begin m_x = e.x; m_y = e.y; end
          if (e.kind == 3) m_d = e.d;
        end
      end
      chk("seed_x", seed_x, m_x);
      chk("seed_y", seed_y, m_y);
      chk("dir", dir, m_d);
    end
  end

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  // Reference model: a well-formed packet with a known command produces exactly one event
  task automatic push_exp(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1);
    exp_t x;
    x.kind = 0; x.x = d0[5:0]; x.y = d1[5:0]; x.d = d0[1:0]; x.c0 = cyc;
    if (cmd == 8'h01) x.kind = 1;
    if (cmd == 8'h02) x.kind = 2;
    if (cmd == 8'h03) x.kind = 3;
    if (x.kind != 0) q.push_back(x);
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] sum, input int gap);
    send_byte(8'hA5, 1'b1); idle_cycles(gap);
    send_byte(cmd, 1'b1);   idle_cycles(gap);
    send_byte(d0, 1'b1);    idle_cycles(gap);
    send_byte(d1, 1'b1);    idle_cycles(gap);
    if (sum == (cmd ^ d0 ^ d1)) push_exp(cmd, d0, d1);
    else                        exp_err = 1'b1;
    send_byte(sum, 1'b1);
  endtask

  task automatic chk_err(input string name);
    idle_cycles(6);
    @(negedge clk);
    chk(name, con_error, exp_err);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    @(negedge clk);
    chk({name, "_start_game"}, start_game, 0);
    chk({name, "_seed_vld"}, seed_vld, 0);
    chk({name, "_dir_vld"}, dir_vld, 0);
    chk({name, "_con_error"}, con_error, 0);
    chk({name, "_seed_x"}, seed_x, 0);
    chk({name, "_seed_y"}, seed_y, 0);
    chk({name, "_dir"}, dir, 0);
  endtask

  initial begin
    logic [7:0] cmd, d0, d1, sum, nb;
    int gap;

    rst = 1'b1; rx = 1'b1; err_clr = 1'b0;
    repeat (5) @(posedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(4);

    // START packet
    send_pkt(8'h01, 8'h00, 8'h00, 8'h01, 0);
    chk_err("start_no_error");

    // SEED then DIR back-to-back
    send_pkt(8'h02, 8'h11, 8'h2A, 8'h39, 0);
    send_pkt(8'h03, 8'h02, 8'h00, 8'h01, 0);
    chk_err("seed_dir_no_error");

    // Bad checksum, then clear, then a good packet
    send_pkt(8'h02, 8'h11, 8'h2A, 8'h38, 0);
    chk_err("bad_sum_sets_error");
    clear_err();
    chk_err("err_clr_clears");
    send_pkt(8'h02, 8'h05, 8'h07, 8'h02 ^ 8'h05 ^ 8'h07, 3);
    chk_err("after_clear_no_error");

    // Framing error inside a packet, then resync on a START packet
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b0);
    exp_err = 1'b1;
    idle_cycles(2 * CPB);
    chk_err("framing_sets_error");
    clear_err();
    send_pkt(8'h01, 8'h00, 8'h00, 8'h01, 0);
    chk_err("after_framing_no_error");

    // Short low glitch in the middle of a packet must not become a byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    idle_cycles(CPB);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    push_exp(8'h01, 8'h00, 8'h00);
    send_byte(8'h01, 1'b1);
    chk_err("glitch_no_error");

    // Noise bytes ahead of the sync byte
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_pkt(8'h03, 8'h01, 8'h00, 8'h02, 0);
    chk_err("noise_no_error");

    // Inter-byte timeout
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    idle_cycles(TO - 40);
    @(negedge clk);
    chk("timeout_not_yet", con_error, 0);
    idle_cycles(80);
    @(negedge clk);
    chk("timeout_sets_error", con_error, 1);
    exp_err = 1'b1;
    @(posedge clk); #1;
    clear_err();

    // Reset in the middle of a byte of a partial packet, with error set
    send_pkt(8'h01, 8'h00, 8'h00, 8'h00, 0);
    chk_err("pre_reset_error");
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    chk_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 1'b0;
    idle_cycles(2);
    send_pkt(8'h02, 8'h3F, 8'h15, 8'h02 ^ 8'h3F ^ 8'h15, 1);
    chk_err("after_reset_no_error");

    // Randomized packets with noise, corrupted checksums and random gaps
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb, 1'b1);
      end
      case ($urandom_range(0, 6))
        0, 1:    cmd = 8'h02;
        2, 3:    cmd = 8'h03;
        4:       cmd = 8'h01;
        default: cmd = 8'($urandom_range(0, 255));
      endcase
      d0  = 8'($urandom_range(0, 255));
      d1  = 8'($urandom_range(0, 255));
      sum = cmd ^ d0 ^ d1;
      if ($urandom_range(0, 4) == 0) sum = sum ^ (8'h01 << $urandom_range(0, 7));
      gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
      send_pkt(cmd, d0, d1, sum, gap);
      chk_err("rand_con_error");
      if (exp_err && ($urandom_range(0, 1) == 1)) clear_err();
    end

    // Drain: every expected event must have been observed
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
